// File: rtl/bp_pkg.sv
// Shared types for the fetch branch predictor: counter encoding, BTB entry
// layout and index/tag helpers.
package bp_pkg;

    // Default number of index bits; 2**BP_INDEX_W table entries.
    localparam int BP_INDEX_W = 6;
    // Tag field sized for the smallest legal index (pc[31:2] >> INDEX_W is
    // right-aligned), so one entry layout serves every INDEX_W.
    localparam int BP_TAG_W   = 30;

    // 2-bit bimodal counter states.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = WNT;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    // Tag of a PC for a table with index_w index bits (upper bits zero).
    function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [31:0] pc, input int index_w);
        logic [31:0] w_shift;
        w_shift = pc >> (index_w + 2);
        return w_shift[BP_TAG_W-1:0];
    endfunction

endpackage

// File: rtl/bp_table.sv
// BHT + BTB storage: one combinational lookup port, one clocked update port.
// Lookups see pre-update contents; an update lands at the clock edge.
module bp_table
    import bp_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [INDEX_W-1:0]  i_rd_idx,
    input  logic [BP_TAG_W-1:0] i_rd_tag,
    output logic                o_rd_hit,
    output logic [1:0]          o_rd_ctr,
    output logic [31:0]         o_rd_target,
    input  logic                i_upd_en,
    input  logic [INDEX_W-1:0]  i_upd_idx,
    input  logic [BP_TAG_W-1:0] i_upd_tag,
    input  logic                i_upd_taken,
    input  logic [31:0]         i_upd_target
);
    localparam int ENTRIES = 2 ** INDEX_W;

    logic [1:0] w_bht [ENTRIES];
    btb_entry_t w_btb [ENTRIES];
    logic [1:0] w_upd_cur;
    logic [1:0] w_upd_next;

    // Saturating counter step for the entry being updated.
    always_comb begin
        w_upd_cur  = w_bht[i_upd_idx];
        w_upd_next = w_upd_cur;
        if (i_upd_taken) begin
            if (w_upd_cur != ST)  w_upd_next = w_upd_cur + 2'd1;
        end else begin
            if (w_upd_cur != SNT) w_upd_next = w_upd_cur - 2'd1;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        logic [1:0] r_bht;
        btb_entry_t r_btb;

        // Per-entry state: counter always steps, BTB only filled on taken.
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_bht <= BHT_RESET;
                r_btb <= '0;
            end else if (i_upd_en && (i_upd_idx == INDEX_W'(g))) begin
                r_bht <= w_upd_next;
                if (i_upd_taken) begin
                    r_btb.valid  <= 1'b1;
                    r_btb.tag    <= i_upd_tag;
                    r_btb.target <= i_upd_target;
                end
            end
        end

        assign w_bht[g] = r_bht;
        assign w_btb[g] = r_btb;
    end

    // Lookup port.
    always_comb begin
        o_rd_hit    = w_btb[i_rd_idx].valid && (w_btb[i_rd_idx].tag == i_rd_tag);
        o_rd_ctr    = w_bht[i_rd_idx];
        o_rd_target = w_btb[i_rd_idx].target;
    end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Fetch PC generator with bimodal BHT + direct-mapped BTB prediction and
// EX-stage redirect. Optional statistics counters under `BP_STATS_EN.
module fetch_branch_predictor
    import bp_pkg::*;
#(
    parameter int          INDEX_W  = BP_INDEX_W,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_fetch,
    input  logic        i_ex_br_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic [31:0] o_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_flush_decode,
    output logic        o_flush_execute,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_inc;
    logic        w_hit;
    logic [1:0]  w_ctr;
    logic [31:0] w_btb_target;
    logic        w_mispred;

    assign w_pc_inc = r_pc + 32'd4;

    bp_table #(.INDEX_W(INDEX_W)) u_table (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rd_idx     (r_pc[INDEX_W+1:2]),
        .i_rd_tag     (bp_tag(r_pc, INDEX_W)),
        .o_rd_hit     (w_hit),
        .o_rd_ctr     (w_ctr),
        .o_rd_target  (w_btb_target),
        .i_upd_en     (i_ex_br_valid),
        .i_upd_idx    (i_ex_pc[INDEX_W+1:2]),
        .i_upd_tag    (bp_tag(i_ex_pc, INDEX_W)),
        .i_upd_taken  (i_ex_taken),
        .i_upd_target (i_ex_target)
    );

    // Prediction for the current fetch PC and mispredict detect for EX.
    always_comb begin
        o_pred_taken  = w_hit && w_ctr[1];
        o_pred_target = w_hit ? w_btb_target : w_pc_inc;
        w_mispred     = i_ex_br_valid &&
                        ((i_ex_taken != i_ex_pred_taken) ||
                         (i_ex_taken && (i_ex_target != i_ex_pred_target)));
    end

    assign o_flush_decode  = w_mispred;
    assign o_flush_execute = w_mispred;
    assign o_pc            = r_pc;

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        if (w_mispred)          w_pc_next = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
        else if (i_stall_fetch) w_pc_next = r_pc;
        else if (o_pred_taken)  w_pc_next = o_pred_target;
        else                    w_pc_next = w_pc_inc;
    end

    // Fetch PC register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_pc <= RESET_PC;
        else          r_pc <= w_pc_next;
    end

`ifdef BP_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    // Resolved-branch and mispredict counters, free-running and wrapping.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (i_ex_br_valid) r_br_count      <= r_br_count + 32'd1;
            if (w_mispred)     r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

    assign o_br_count      = r_br_count;
    assign o_mispred_count = r_mispred_count;
`else
    assign o_br_count      = 32'h0;
    assign o_mispred_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed-vector bench for fetch_branch_predictor. The driver pushes the
// hand-computed expected outputs for each cycle; a monitor pops and compares
// on the falling edge.
module tb_fetch_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        brv;
    logic [31:0] ex_pc;
    logic        ex_tk;
    logic [31:0] ex_tgt;
    logic        ex_ptk;
    logic [31:0] ex_ptgt;
    logic [31:0] pc;
    logic        pred_tk;
    logic [31:0] pred_tgt;
    logic        fl_dec;
    logic        fl_ex;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
        logic [31:0] brc;
        logic [31:0] misc;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          step_id = 0;
    logic [31:0] m_br = '0;
    logic [31:0] m_mis = '0;

    fetch_branch_predictor #(.INDEX_W(6), .RESET_PC(32'h0)) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_stall_fetch    (stall),
        .i_ex_br_valid    (brv),
        .i_ex_pc          (ex_pc),
        .i_ex_taken       (ex_tk),
        .i_ex_target      (ex_tgt),
        .i_ex_pred_taken  (ex_ptk),
        .i_ex_pred_target (ex_ptgt),
        .o_pc             (pc),
        .o_pred_taken     (pred_tk),
        .o_pred_target    (pred_tgt),
        .o_flush_decode   (fl_dec),
        .o_flush_execute  (fl_ex),
        .o_br_count       (br_cnt),
        .o_mispred_count  (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic step(input logic s, input logic v, input logic [31:0] epc,
                        input logic tk, input logic [31:0] tg,
                        input logic ptk, input logic [31:0] ptg,
                        input logic [31:0] e_pc, input logic e_pt,
                        input logic [31:0] e_ptgt, input logic e_fl);
        exp_t e;
        @(posedge clk);
        #1;
        stall = s; brv = v; ex_pc = epc; ex_tk = tk; ex_tgt = tg;
        ex_ptk = ptk; ex_ptgt = ptg;
        step_id++;
        e.id = step_id; e.pc = e_pc; e.pt = e_pt; e.ptgt = e_ptgt; e.fl = e_fl;
`ifdef BP_STATS_EN
        e.brc = m_br; e.misc = m_mis;
`else
        e.brc = '0; e.misc = '0;
`endif
        q.push_back(e);
        if (v)    m_br  = m_br + 32'd1;
        if (e_fl) m_mis = m_mis + 32'd1;
    endtask

    task automatic idle(input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ptgt);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, e_pc, e_pt, e_ptgt, 1'b0);
    endtask

    // Redirect via a not-taken branch at (target-4) that was predicted taken.
    task automatic redirect_nt(input logic [31:0] to_pc, input logic [31:0] e_pc,
                               input logic [31:0] e_ptgt);
        step(1'b0, 1'b1, to_pc - 32'd4, 1'b0, 32'h0, 1'b1, to_pc, e_pc, 1'b0, e_ptgt, 1'b1);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (pc !== e.pc) begin
                miscompares++;
                $display("FAIL v%0d pc: got %h want %h", e.id, pc, e.pc);
            end
            if (pred_tk !== e.pt) begin
                miscompares++;
                $display("FAIL v%0d pred_taken: got %b want %b", e.id, pred_tk, e.pt);
            end
            if (pred_tgt !== e.ptgt) begin
                miscompares++;
                $display("FAIL v%0d pred_target: got %h want %h", e.id, pred_tgt, e.ptgt);
            end
            if (fl_dec !== e.fl || fl_ex !== e.fl) begin
                miscompares++;
                $display("FAIL v%0d flush: got dec=%b ex=%b want %b", e.id, fl_dec, fl_ex, e.fl);
            end
            if (br_cnt !== e.brc || mis_cnt !== e.misc) begin
                miscompares++;
                $display("FAIL v%0d stats: got br=%0d mis=%0d want br=%0d mis=%0d",
                         e.id, br_cnt, mis_cnt, e.brc, e.misc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; brv = 1'b0; ex_pc = '0; ex_tk = 1'b0;
        ex_tgt = '0; ex_ptk = 1'b0; ex_ptgt = '0;

        // Reset state.
        idle(32'h0, 1'b0, 32'h4);
        #6 rst_n = 1'b1;

        // Sequential fetch; stall asserted while at 0x20.
        for (int k = 1; k <= 8; k++)
            step(k == 8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'(4 * k), 1'b0, 32'(4 * k + 4), 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b0, 32'h24, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b0, 32'h24, 1'b0);
        idle(32'h20, 1'b0, 32'h24);
        // Stall together with a taken mispredict: redirect wins.
        step(1'b1, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 32'h24, 1'b0, 32'h28, 1'b1);
        // Train 0x40 taken -> 0x100 (correctly predicted, no flush).
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 32'h204, 1'b0);
        redirect_nt(32'h40, 32'h204, 32'h208);
        idle(32'h40, 1'b1, 32'h100);
        // Mispredict at 0x40: predicted taken, actually not taken.
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 32'h100, 1'b0, 32'h104, 1'b1);
        redirect_nt(32'h40, 32'h44, 32'h48);
        // Counter back to 01: hit but not taken, target still from BTB.
        idle(32'h40, 1'b0, 32'h100);
        // Five taken updates saturate at 11.
        for (int j = 0; j < 5; j++)
            step(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100,
                 32'(32'h44 + 4 * j), 1'b0, 32'(32'h48 + 4 * j), 1'b0);
        // One not-taken: 11 -> 10, still predicts taken.
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h58, 1'b0, 32'h5C, 1'b0);
        redirect_nt(32'h40, 32'h5C, 32'h60);
        // Same-index update this cycle: lookup still sees 10.
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0, 32'h104, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h104, 1'b0, 32'h108, 1'b0);
        redirect_nt(32'h40, 32'h108, 32'h10C);
        // Counter at 00 (no underflow); retrain to 11.
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 32'h40, 1'b0, 32'h100, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 32'h44, 1'b0, 32'h48, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 32'h48, 1'b0, 32'h4C, 1'b0);
        redirect_nt(32'h140, 32'h4C, 32'h50);
        // Alias: same index as 0x40, different tag.
        idle(32'h140, 1'b0, 32'h144);
        // Wrap: redirect to 0xFFFF_FFFC, its +4 is 0.
        step(1'b0, 1'b1, 32'h500, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h504, 32'h144, 1'b0, 32'h148, 1'b1);
        idle(32'hFFFF_FFFC, 1'b0, 32'h0);
        // Not-taken mispredict at 0xFFFF_FFFC: fall-through wraps to 0.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h4, 1'b1);
        // Taken with the wrong predicted target.
        step(1'b0, 1'b1, 32'h600, 1'b1, 32'h800, 1'b1, 32'h700, 32'h0, 1'b0, 32'h4, 1'b1);
        idle(32'h800, 1'b0, 32'h804);
        // Reset mid-operation.
        #6 rst_n = 1'b0;
        m_br = '0; m_mis = '0;
        idle(32'h0, 1'b0, 32'h4);
        #6 rst_n = 1'b1;
        redirect_nt(32'h40, 32'h4, 32'h8);
        // BTB cleared by reset: 0x40 no longer hits.
        idle(32'h40, 1'b0, 32'h44);
        idle(32'h44, 1'b0, 32'h48);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_branch_predictor.md
Name: fetch_branch_predictor

Overview:
- Fetch-stage PC generator with a 2-bit bimodal branch history table (BHT) and a direct-mapped branch target buffer (BTB).
- Sits directly upstream of instruction memory. o_pc drives the instruction memory address.
- o_flush_decode drives the instruction memory decode-flush input.
- Resolves redirects from EX-stage branch outcomes and carries the prediction down the pipe for later checking.

Parameters:
- INDEX_W, 6: BHT/BTB index width; 2**INDEX_W entries.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_stall_fetch  in  1  hold PC (hazard stall).
- i_ex_br_valid  in  1  EX resolves a branch/jump this cycle.
- i_ex_pc  in  32  PC of the resolved branch.
- i_ex_taken  in  1  actual outcome.
- i_ex_target  in  32  actual target address.
- i_ex_pred_taken  in  1  prediction carried with that branch.
- i_ex_pred_target  in  32  predicted target carried with that branch.
- o_pc  out  32  current fetch PC.
- o_pred_taken  out  1  prediction for o_pc.
- o_pred_target  out  32  predicted target for o_pc.
- o_flush_decode  out  1  squash the IF/ID instruction.
- o_flush_execute  out  1  squash the ID/EX instruction.
- o_br_count  out  32  resolved-branch count (optional feature).
- o_mispred_count  out  32  mispredict count (optional feature).

Behaviour:
- Reset (async, active-low):
  - o_pc = RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - Statistics counters = 0.
- Index and tag: index = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2].
- BTB entry contents: valid, tag, 32-bit target.
- Lookup (combinational on o_pc):
  - hit = valid && tag match.
  - o_pred_taken = hit && counter[1].
  - o_pred_target = BTB target when hit, else o_pc+4.
- Mispredict = i_ex_br_valid && (i_ex_taken != i_ex_pred_taken || (i_ex_taken && i_ex_target != i_ex_pred_target)).
- o_flush_decode = o_flush_execute = mispredict. Both are combinational, asserted in the resolving cycle.
- Next-PC priority:
  1. Mispredict: i_ex_taken ? i_ex_target : i_ex_pc+4. Overrides stall.
  2. i_stall_fetch: hold o_pc.
  3. o_pred_taken: o_pred_target.
  4. Otherwise: o_pc+4.
- PC arithmetic is 32-bit wrapping; 0xFFFF_FFFC+4 = 0.
- Update on i_ex_br_valid at the clock edge, independent of stall:
  - Counter at index(i_ex_pc): taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - If taken: BTB entry written with valid=1, tag(i_ex_pc), i_ex_target.
  - Not-taken never clears valid.
- Same-index read/update in one cycle: the lookup sees pre-update contents; the update is visible next cycle.
- Reset mid-operation: all state returns to reset values immediately; flush outputs go low with i_ex_br_valid low.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - o_br_count increments on each i_ex_br_valid.
  - o_mispred_count increments on each mispredict.
  - Both are 32-bit wrapping and reset to 0.
- Undefined: the counter registers are not built; both ports are tied to 32'h0.

Decomposition:
- Package bp_pkg:
  - Counter state enum (SNT, WNT, WT, ST) and the 2'b01 reset constant.
  - BTB entry struct (valid, tag, target).
  - Index/tag width helper constants derived from INDEX_W.
- Sub-module bp_table: the BHT + BTB storage.
  - One combinational read port and one clocked update port, async reset.
  - Owns the saturating-counter logic.
- The top level holds the PC register, next-PC mux, mispredict compare and the optional statistics.

Test Plan:
- Release reset, no branches, no stalls: o_pc = 0x0, 0x4, 0x8, 0xC on successive cycles; o_pred_taken = 0.
- Resolve taken branch at i_ex_pc=0x40, i_ex_target=0x100:
  - Counter goes 01→10 and the BTB entry becomes valid.
  - Next fetch of 0x40 gives o_pred_taken=1, o_pred_target=0x100, then o_pc=0x100.
- Mispredict: i_ex_pc=0x40, pred_taken=1, taken=0.
  - o_flush_decode = o_flush_execute = 1 that cycle.
  - Next o_pc = 0x44; counter 10→01.
- Stall and redirect:
  - i_stall_fetch=1 for 3 cycles at o_pc=0x20: o_pc holds 0x20.
  - Stall together with a mispredict redirect to 0x200: o_pc = 0x200 next cycle.
- Saturation at 0x40:
  - Five taken updates give counter 11.
  - One not-taken gives 10; still predicts taken.
  - Three more not-taken give 00; no underflow.
- Alias check (INDEX_W=6):
  - 0x40 trained taken.
  - Fetch 0x140 (same index, different tag): o_pred_taken=0, next o_pc=0x144.
  - With BP_STATS_EN, o_br_count and o_mispred_count match the issued totals.
